// File: rtl/axil_write_firewall_ctrl.sv
// AXI4-Lite write-channel firewall: blocked writes inside [PROT_LO, PROT_HI] complete locally
// with SLVERR; allowed writes are forwarded and their downstream B response is relayed.
module axil_write_firewall_ctrl #(
  parameter int unsigned          ADDR_W  = 32,
  parameter int unsigned          DATA_W  = 32,
  parameter logic [ADDR_W-1:0]    PROT_LO = ADDR_W'(32'h4000_0000),
  parameter logic [ADDR_W-1:0]    PROT_HI = ADDR_W'(32'h4000_FFFF),
  parameter int unsigned          CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  output logic                viol_pulse,
  output logic [CNT_W-1:0]    viol_count,
  output logic [ADDR_W-1:0]   viol_addr,
  input  logic                viol_clear
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StFwd, StWaitB, StResp} state_e;

  state_e              state_q, state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                m_awvalid_q, m_awvalid_d;
  logic                m_wvalid_q, m_wvalid_d;
  logic                viol_pulse_q, viol_pulse_d;
  logic [CNT_W-1:0]    viol_count_q, viol_count_d;
  logic [ADDR_W-1:0]   viol_addr_q, viol_addr_d;
  logic                ready_en_q;
  logic                blocked;
  logic                viol_inc;

  assign blocked = (addr_q >= PROT_LO) && (addr_q <= PROT_HI);

  // ready_en_q keeps the upstream readies low while reset is asserted
  assign s_awready  = ready_en_q && (state_q == StIdle) && !aw_held_q;
  assign s_wready   = ready_en_q && (state_q == StIdle) && !w_held_q;
  assign s_bvalid   = (state_q == StResp);
  assign s_bresp    = bresp_q;
  assign m_awvalid  = m_awvalid_q;
  assign m_awaddr   = addr_q;
  assign m_wvalid   = m_wvalid_q;
  assign m_wdata    = data_q;
  assign m_wstrb    = strb_q;
  assign m_bready   = (state_q == StWaitB);
  assign viol_pulse = viol_pulse_q;
  assign viol_count = viol_count_q;
  assign viol_addr  = viol_addr_q;

  always_comb begin
    state_d      = state_q;
    aw_held_d    = aw_held_q;
    w_held_d     = w_held_q;
    addr_d       = addr_q;
    data_d       = data_q;
    strb_d       = strb_q;
    bresp_d      = bresp_q;
    m_awvalid_d  = m_awvalid_q;
    m_wvalid_d   = m_wvalid_q;
    viol_pulse_d = 1'b0;
    viol_addr_d  = viol_addr_q;
    viol_inc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (aw_held_q && w_held_q) begin
          if (blocked) begin
            state_d      = StResp;
            bresp_d      = 2'b10;
            viol_pulse_d = 1'b1;
            viol_addr_d  = addr_q;
            viol_inc     = 1'b1;
          end else begin
            state_d     = StFwd;
            m_awvalid_d = 1'b1;
            m_wvalid_d  = 1'b1;
          end
        end else begin
          if (s_awvalid && s_awready) begin
            aw_held_d = 1'b1;
            addr_d    = s_awaddr;
          end
          if (s_wvalid && s_wready) begin
            w_held_d = 1'b1;
            data_d   = s_wdata;
            strb_d   = s_wstrb;
          end
        end
      end
      StFwd: begin
        if (m_awvalid_q && m_awready) m_awvalid_d = 1'b0;
        if (m_wvalid_q && m_wready)   m_wvalid_d  = 1'b0;
        if (!m_awvalid_d && !m_wvalid_d) state_d = StWaitB;
      end
      StWaitB: begin
        if (m_bvalid) begin
          bresp_d = m_bresp;
          state_d = StResp;
        end
      end
      StResp: begin
        if (s_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A clear coinciding with a new violation keeps that violation counted
    if (viol_clear) begin
      viol_count_d = viol_inc ? CNT_W'(1) : '0;
    end else if (viol_inc && (viol_count_q != '1)) begin
      viol_count_d = viol_count_q + CNT_W'(1);
    end else begin
      viol_count_d = viol_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      bresp_q      <= 2'b00;
      m_awvalid_q  <= 1'b0;
      m_wvalid_q   <= 1'b0;
      viol_pulse_q <= 1'b0;
      viol_count_q <= '0;
      viol_addr_q  <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      bresp_q      <= bresp_d;
      m_awvalid_q  <= m_awvalid_d;
      m_wvalid_q   <= m_wvalid_d;
      viol_pulse_q <= viol_pulse_d;
      viol_count_q <= viol_count_d;
      viol_addr_q  <= viol_addr_d;
      ready_en_q   <= 1'b1;
    end
  end

endmodule
